data_memory_64: RTL and testbench



---
 rtl/data_memory_64.sv | 90 +++++++++
 tb/tb_data_memory_64.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_64.sv
// Byte-addressable 64-bit data memory for the single-cycle RV64I datapath.
// Little-endian loads/stores with sign/zero extension and misalignment suppression.
module data_memory_64 #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] write_data,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  funct3,
    output logic [63:0] read_data,
    output logic        misaligned
);

    logic [7:0]        mem [DEPTH_BYTES];
    logic [ADDR_W-1:0] index;
    logic              unaligned;
    logic [7:0]        byte_en;
    logic              store_ok;
    logic signed [63:0] raw;
    logic              unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo DEPTH_BYTES.
    assign index          = addr[ADDR_W-1:0];
    assign unused_addr_hi = ^addr[63:ADDR_W];

    function automatic logic [63:0] extend_load(input logic [2:0] f3,
                                                input logic signed [63:0] value);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic signed [63:0] res;
        b = value[7:0];
        h = value[15:0];
        w = value[31:0];
        case (f3)
            3'b000:  res = 64'(b);
            3'b001:  res = 64'(h);
            3'b010:  res = 64'(w);
            3'b011:  res = value;
            3'b100:  res = {56'd0, value[7:0]};
            3'b101:  res = {48'd0, value[15:0]};
            3'b110:  res = {32'd0, value[31:0]};
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        unaligned = 1'b0;
        byte_en   = 8'h00;
        case (funct3[1:0])
            2'b00: begin unaligned = 1'b0;        byte_en = 8'h01; end
            2'b01: begin unaligned = index[0];    byte_en = 8'h03; end
            2'b10: begin unaligned = |index[1:0]; byte_en = 8'h0F; end
            default: begin unaligned = |index[2:0]; byte_en = 8'hFF; end
        endcase
    end

    assign misaligned = (mem_read | mem_write) & unaligned;
    assign store_ok   = mem_write & ~funct3[2] & ~unaligned;

    // Assemble eight bytes starting at index; lowest index lands in bits [7:0].
    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            raw[8*k +: 8] = mem[index + ADDR_W'(k)];
        end
    end

    assign read_data = (mem_read && !unaligned) ? extend_load(funct3, raw) : 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (store_ok) begin
            for (int k = 0; k < 8; k++) begin
                if (byte_en[k]) begin
                    mem[index + ADDR_W'(k)] <= write_data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_64.sv
// Scoreboard bench for data_memory_64: expected loads are queued as stimulus
// is driven and compared against the combinational outputs.
module tb_data_memory_64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] write_data = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] read_data;
    logic        misaligned;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] rd;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    data_memory_64 #(.DEPTH_BYTES(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .funct3     (funct3),
        .read_data  (read_data),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d required=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic do_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        mem_read   = 1'b0;
        funct3     = f3;
        addr       = a;
        write_data = d;
        mem_write  = 1'b1;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
    endtask

    task automatic push_load(input string n, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] rd, input logic mis);
        exp_t e;
        e.name = n; e.f3 = f3; e.a = a; e.rd = rd; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        total++;
        if (misaligned !== 1'b0) $display("FAIL reset_idle_mis: got %0b want 0", misaligned);
        else passed++;
        push_load("reset_ld_10", 3'b011, 64'h10, 64'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
    endtask

    task automatic test_sd_ld;
        exp_t e;
        do_store(3'b011, 64'h08, 64'h8877_6655_4433_2211);
        push_load("lb_0f",  3'b000, 64'h0F, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        push_load("lbu_0f", 3'b100, 64'h0F, 64'h0000_0000_0000_0088, 1'b0);
        push_load("lh_0e",  3'b001, 64'h0E, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
        push_load("lhu_0a", 3'b101, 64'h0A, 64'h0000_0000_0000_4433, 1'b0);
        push_load("lw_0c",  3'b010, 64'h0C, 64'hFFFF_FFFF_8877_6655, 1'b0);
        push_load("lwu_0c", 3'b110, 64'h0C, 64'h0000_0000_8877_6655, 1'b0);
        push_load("ld_08",  3'b011, 64'h08, 64'h8877_6655_4433_2211, 1'b0);
        push_load("rsv_08", 3'b111, 64'h08, 64'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
        #1;
        total++;
        if (read_data !== 64'h0) $display("FAIL read_disabled: got %h want 0", read_data);
        else passed++;
    endtask

    task automatic test_partial;
        exp_t e;
        do_store(3'b000, 64'h09, 64'h0000_0000_0000_00AB);
        do_store(3'b010, 64'h0C, 64'h0000_0000_0000_7FFF);
        do_store(3'b100, 64'h0A, 64'h0000_0000_0000_00EE);
        push_load("ld_08_part", 3'b011, 64'h08, 64'h0000_7FFF_4433_AB11, 1'b0);
        push_load("lw_0c_part", 3'b010, 64'h0C, 64'h0000_0000_0000_7FFF, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
    endtask

    task automatic test_misaligned;
        exp_t e;
        @(negedge clk);
        funct3 = 3'b010; addr = 64'h0A; write_data = 64'hDEAD_BEEF; mem_write = 1'b1;
        #1;
        total++;
        if (misaligned !== 1'b1) $display("FAIL sw_0a_mis: got %0b want 1", misaligned);
        else passed++;
        @(posedge clk);
        #1 mem_write = 1'b0;
        do_store(3'b001, 64'h0B, 64'h0000_0000_0000_CCCC);
        do_store(3'b011, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF);
        push_load("ld_08_kept", 3'b011, 64'h08, 64'h0000_7FFF_4433_AB11, 1'b0);
        push_load("ld_04_mis",  3'b011, 64'h04, 64'h0, 1'b1);
        push_load("lh_0f_mis",  3'b001, 64'h0F, 64'h0, 1'b1);
        push_load("lw_0e_mis",  3'b010, 64'h0E, 64'h0, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
    endtask

    task automatic test_wrap_simul;
        exp_t e;
        do_store(3'b011, 64'h1_0000_0100, 64'h0000_0000_0000_1234);
        push_load("ld_00_wrap", 3'b011, 64'h00, 64'h0000_0000_0000_1234, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        @(negedge clk);
        funct3 = 3'b011; addr = 64'h00; write_data = 64'h5678; mem_read = 1'b1; mem_write = 1'b1;
        push_load("simul_pre",  3'b011, 64'h00, 64'h0000_0000_0000_1234, 1'b0);
        #1;
        e = sb.pop_front();
        total++;
        if (read_data !== e.rd || misaligned !== e.mis)
            $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
        else passed++;
        @(posedge clk);
        push_load("simul_post", 3'b011, 64'h00, 64'h0000_0000_0000_5678, 1'b0);
        #1 mem_write = 1'b0;
        #1;
        e = sb.pop_front();
        total++;
        if (read_data !== e.rd || misaligned !== e.mis)
            $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
        else passed++;
        mem_read = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge clk);
        funct3 = 3'b011; addr = 64'h18; write_data = 64'h1111_1111_1111_1111; mem_write = 1'b1;
        @(posedge clk);
        #1 write_data = 64'h2222_3333_4444_5555;
        @(posedge clk);
        #1 mem_write = 1'b0;
        push_load("b2b_last", 3'b011, 64'h18, 64'h2222_3333_4444_5555, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        do_store(3'b011, 64'h20, 64'h0000_0000_0000_FFFF);
        @(negedge clk);
        funct3 = 3'b011; addr = 64'h20; mem_read = 1'b1;
        push_load("ld_20_pre", 3'b011, 64'h20, 64'h0000_0000_0000_FFFF, 1'b0);
        #1;
        e = sb.pop_front();
        total++;
        if (read_data !== e.rd) $display("FAIL %s: got %h want %h", e.name, read_data, e.rd);
        else passed++;
        reset = 1'b1;
        push_load("ld_20_rst", 3'b011, 64'h20, 64'h0, 1'b0);
        #1;
        e = sb.pop_front();
        total++;
        if (read_data !== e.rd) $display("FAIL %s: got %h want %h", e.name, read_data, e.rd);
        else passed++;
        write_data = 64'hABCD; mem_write = 1'b1;
        @(posedge clk);
        #1 mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        push_load("ld_20_blocked", 3'b011, 64'h20, 64'h0, 1'b0);
        push_load("ld_08_cleared", 3'b011, 64'h08, 64'h0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            funct3 = e.f3; addr = e.a; mem_read = 1'b1;
            #1;
            total++;
            if (read_data !== e.rd || misaligned !== e.mis)
                $display("FAIL %s: got rd=%h mis=%0b want rd=%h mis=%0b", e.name, read_data, misaligned, e.rd, e.mis);
            else passed++;
        end
        mem_read = 1'b0;
    endtask

    initial begin
        test_reset;
        test_sd_ld;
        test_partial;
        test_misaligned;
        test_wrap_simul;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
